cpfsk_audio_mod: RTL and testbench

- Continuous-phase binary FSK modulator producing 8-bit unsigned audio samples.
- Generates a bit clock and a reset for an external data source (a 32-bit xorshift PRNG clocked by `clk_out`).
- Samples the returned data bit once per bit period and steers a phase-accumulator NCO between mark and space tones.
- `audio_out` feeds a downstream 8-bit PWM stage that resamples it every 256 carrier clocks.

---
 rtl/cpfsk_audio_mod.sv | 115 +++++++++++
 tb/tb_cpfsk_audio_mod.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cpfsk_audio_mod.sv
`timescale 1ns/1ps
// Continuous-phase binary FSK modulator: NCO steered by a sampled data bit, 8-bit sine output.
// Also supplies the bit clock and a power-on reset for the external data source.
module cpfsk_audio_mod #(
  parameter int PHASE_W   = 24,
  parameter int MARK_INC  = 5592,
  parameter int SPACE_INC = 3050,
  parameter int BAUD_DIV  = 5500,
  parameter int RST_BITS  = 2
) (
  input  logic       clk_in,
  input  logic       sys_rst_n,
  input  logic       data,
  output logic       clk_out,
  output logic       cpfsk_rst,
  output logic [7:0] audio_out
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = (RST_BITS < 2) ? 1 : $clog2(RST_BITS);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_HALF   = CNT_W'(BAUD_DIV / 2);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(RST_BITS - 1);
  localparam logic [PHASE_W-1:0] MARK_STEP  = PHASE_W'(MARK_INC);
  localparam logic [PHASE_W-1:0] SPACE_STEP = PHASE_W'(SPACE_INC);

  logic [CNT_W-1:0]   r_baud_cnt;
  logic               r_clk_out;
  logic               r_cpfsk_rst;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_cur_bit;
  logic [PHASE_W-1:0] r_phase;
  logic [7:0]         r_audio;

  logic               w_wrap;
  logic [CNT_W-1:0]   w_baud_cnt_next;
  logic [PHASE_W-1:0] w_phase_inc;
  logic [7:0]         w_idx;
  logic [6:0]         w_qidx;
  logic [6:0]         w_qmag;
  logic [7:0]         w_sample;

  assign w_wrap          = (r_baud_cnt == CNT_LAST);
  assign w_baud_cnt_next = w_wrap ? '0 : r_baud_cnt + CNT_W'(1);

  // The bit-period counter stops once the source reset has been released.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_baud_cnt  <= '0;
      r_clk_out   <= 1'b0;
      r_cpfsk_rst <= 1'b1;
      r_bit_cnt   <= '0;
      r_cur_bit   <= 1'b0;
    end else begin
      r_baud_cnt <= w_baud_cnt_next;
      r_clk_out  <= (w_baud_cnt_next < CNT_HALF);
      if (w_wrap) begin
        r_cur_bit <= data & ~r_cpfsk_rst;
        if (r_cpfsk_rst) begin
          if (r_bit_cnt == BIT_LAST) begin
            r_cpfsk_rst <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
      end
    end
  end

  assign w_phase_inc = r_cur_bit ? MARK_STEP : SPACE_STEP;

  // Phase is never cleared on a bit change, which keeps the output phase-continuous.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_phase <= '0;
      r_audio <= 8'd128;
    end else begin
      r_phase <= r_phase + w_phase_inc;
      r_audio <= w_sample;
    end
  end

  assign w_idx  = r_phase[PHASE_W-1 -: 8];
  assign w_qidx = w_idx[6] ? (7'd64 - {1'b0, w_idx[5:0]}) : {1'b0, w_idx[5:0]};

  // Quarter wave: round(127*sin(pi*k/128)) for k = 0..64.
  always_comb begin
    w_qmag = 7'd127;
    case (w_qidx)
      7'd0:  w_qmag = 7'd0;   7'd1:  w_qmag = 7'd3;   7'd2:  w_qmag = 7'd6;   7'd3:  w_qmag = 7'd9;
      7'd4:  w_qmag = 7'd12;  7'd5:  w_qmag = 7'd16;  7'd6:  w_qmag = 7'd19;  7'd7:  w_qmag = 7'd22;
      7'd8:  w_qmag = 7'd25;  7'd9:  w_qmag = 7'd28;  7'd10: w_qmag = 7'd31;  7'd11: w_qmag = 7'd34;
      7'd12: w_qmag = 7'd37;  7'd13: w_qmag = 7'd40;  7'd14: w_qmag = 7'd43;  7'd15: w_qmag = 7'd46;
      7'd16: w_qmag = 7'd49;  7'd17: w_qmag = 7'd51;  7'd18: w_qmag = 7'd54;  7'd19: w_qmag = 7'd57;
      7'd20: w_qmag = 7'd60;  7'd21: w_qmag = 7'd63;  7'd22: w_qmag = 7'd65;  7'd23: w_qmag = 7'd68;
      7'd24: w_qmag = 7'd71;  7'd25: w_qmag = 7'd73;  7'd26: w_qmag = 7'd76;  7'd27: w_qmag = 7'd78;
      7'd28: w_qmag = 7'd81;  7'd29: w_qmag = 7'd83;  7'd30: w_qmag = 7'd85;  7'd31: w_qmag = 7'd88;
      7'd32: w_qmag = 7'd90;  7'd33: w_qmag = 7'd92;  7'd34: w_qmag = 7'd94;  7'd35: w_qmag = 7'd96;
      7'd36: w_qmag = 7'd98;  7'd37: w_qmag = 7'd100; 7'd38: w_qmag = 7'd102; 7'd39: w_qmag = 7'd104;
      7'd40: w_qmag = 7'd106; 7'd41: w_qmag = 7'd107; 7'd42: w_qmag = 7'd109; 7'd43: w_qmag = 7'd111;
      7'd44: w_qmag = 7'd112; 7'd45: w_qmag = 7'd113; 7'd46: w_qmag = 7'd115; 7'd47: w_qmag = 7'd116;
      7'd48: w_qmag = 7'd117; 7'd49: w_qmag = 7'd118; 7'd50: w_qmag = 7'd120; 7'd51: w_qmag = 7'd121;
      7'd52: w_qmag = 7'd122; 7'd53: w_qmag = 7'd122; 7'd54: w_qmag = 7'd123; 7'd55: w_qmag = 7'd124;
      7'd56: w_qmag = 7'd125; 7'd57: w_qmag = 7'd125; 7'd58: w_qmag = 7'd126; 7'd59: w_qmag = 7'd126;
      7'd60: w_qmag = 7'd126; 7'd61: w_qmag = 7'd127; 7'd62: w_qmag = 7'd127; 7'd63: w_qmag = 7'd127;
      default: w_qmag = 7'd127;
    endcase
  end

  assign w_sample = w_idx[7] ? (8'd128 - {1'b0, w_qmag}) : (8'd128 + {1'b0, w_qmag});

  assign clk_out   = r_clk_out;
  assign cpfsk_rst = r_cpfsk_rst;
  assign audio_out = r_audio;
endmodule

// File: tb/tb_cpfsk_audio_mod.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for cpfsk_audio_mod: constant-mark run, mid-run async reset,
// then an xorshift32 source with random off-sample data glitches.
module tb_cpfsk_audio_mod;
  localparam int D        = 5500;
  localparam int HALF     = D / 2;
  localparam int RST_BITS = 2;
  localparam int MARK     = 5592;
  localparam int SPACE    = 3050;

  logic       clk_in = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       data = 1'b0;
  logic       clk_out;
  logic       cpfsk_rst;
  logic [7:0] audio_out;

  cpfsk_audio_mod dut (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .clk_out   (clk_out),
    .cpfsk_rst (cpfsk_rst),
    .audio_out (audio_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int n;
    bit clk;
    bit rst;
    int audio;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  bit          done = 0;
  int          m_n;
  logic [23:0] m_phase;
  bit          period_bits[0:15];
  logic [31:0] src, seed;
  bit          prev_clk, prev_rst;
  bit          track = 0;
  int          amin, amax;

  function automatic int sine_ref(input int idx);
    real v;
    int  r;
    v = 128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * real'(idx) / 256.0);
    r = $rtoi(v + 0.5);
    if (r < 1) r = 1;
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  task automatic finish_sim();
    if (!done) begin
      done = 1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: one expected output tuple per clock, compared mid-cycle.
  always @(negedge clk_in) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if (clk_out !== mon_e.clk || cpfsk_rst !== mon_e.rst || audio_out !== 8'(mon_e.audio)) begin
        bad++;
        $display("FAIL cycle n=%0d: got clk_out=%0b cpfsk_rst=%0b audio=%0d, want %0b %0b %0d",
                 mon_e.n, clk_out, cpfsk_rst, audio_out, mon_e.clk, mon_e.rst, mon_e.audio);
        if (bad >= 40) finish_sim();
      end
    end
  end

  task automatic run_cycles(input int ncyc, input bit use_src, input bit glitch_en);
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_in);
      m_n++;
      // The sample after edge n is the table value of the phase before it.
      e.n     = m_n;
      e.clk   = ((m_n % D) < HALF);
      e.rst   = (m_n < RST_BITS * D);
      e.audio = sine_ref(int'(m_phase[23:16]));
      m_phase = m_phase + (period_bits[(m_n - 1) / D] ? 24'(MARK) : 24'(SPACE));
      sb_q.push_back(e);
      if (m_n % D == 0)
        $display("bit period %0d starts: expected bit=%0d checks=%0d bad=%0d",
                 m_n / D, period_bits[m_n / D], total, bad);
      @(negedge clk_in);
      if (use_src) begin
        if (clk_out && !prev_clk) src = prev_rst ? seed : xs32(src);
        prev_clk = clk_out;
        prev_rst = cpfsk_rst;
        data = src[0];
        if (glitch_en && (m_n % D) != D - 1 && $urandom_range(7) == 0) data = ~data;
      end else begin
        data = 1'b1;
      end
      if (track && m_n > RST_BITS * D) begin
        if (int'(audio_out) < amin) amin = int'(audio_out);
        if (int'(audio_out) > amax) amax = int'(audio_out);
      end
    end
  endtask

  initial begin
    logic [31:0] x;
    sys_rst_n = 1'b0;
    data = 1'b0;
    repeat (2) @(negedge clk_in);
    check("reset clk_out", int'(clk_out), 0);
    check("reset cpfsk_rst", int'(cpfsk_rst), 1);
    check("reset audio", int'(audio_out), 128);

    // Constant mark: source reset must hold cur_bit at space for RST_BITS periods.
    for (int k = 0; k < 16; k++) period_bits[k] = (k > RST_BITS);
    m_n = 0;
    m_phase = '0;
    amin = 255;
    amax = 0;
    track = 1;
    data = 1'b1;
    sys_rst_n = 1'b1;
    run_cycles(3 * D + D / 2 + int'($urandom_range(1500)), 1'b0, 1'b0);
    track = 0;
    check("mark run peak", amax, 255);
    check("mark run trough", amin, 1);

    // Asynchronous reset mid-run, away from any clock edge.
    #2 sys_rst_n = 1'b0;
    #1;
    check("async reset clk_out", int'(clk_out), 0);
    check("async reset cpfsk_rst", int'(cpfsk_rst), 1);
    check("async reset audio", int'(audio_out), 128);
    repeat (2) @(negedge clk_in);
    check("held reset audio", int'(audio_out), 128);
    check("held reset clk_out", int'(clk_out), 0);

    // PRNG source: first data period carries bit 0 of the seed.
    seed = $urandom | 32'h1;
    x = seed;
    for (int k = 0; k < 16; k++) begin
      if (k <= RST_BITS) begin
        period_bits[k] = 1'b0;
      end else begin
        period_bits[k] = x[0];
        x = xs32(x);
      end
    end
    src = '0;
    prev_clk = 1'b0;
    prev_rst = 1'b1;
    m_n = 0;
    m_phase = '0;
    sys_rst_n = 1'b1;
    run_cycles(8 * D, 1'b1, 1'b1);
    @(negedge clk_in);
    check("scoreboard drained", sb_q.size(), 0);
    finish_sim();
  end
endmodule
